// File: rtl/fruta_gen_if.sv
// Signal bundle between the fruit generator, its requester and the map memory.
// Handshake: the requester pulses fruta_enable; each request gets one fruta_wenable pulse and the position is sampled from fruta_wx/fruta_wy in that cycle. gen_rdata answers a gen_renable exactly one cycle later.
interface fruta_gen_if;
    logic       fruta_enable;
    logic       fruta_wenable;
    logic [9:0] fruta_wx;
    logic [9:0] fruta_wy;
    logic       gen_renable;
    logic [9:0] gen_rx;
    logic [9:0] gen_ry;
    logic [1:0] gen_rdata;
    logic       ready;
    logic       map_full;
    logic [2:0] dbg_state;

    modport slave (
        input  fruta_enable, gen_rdata,
        output fruta_wenable, fruta_wx, fruta_wy, gen_renable, gen_rx, gen_ry,
               ready, map_full, dbg_state
    );

    modport master (
        output fruta_enable, gen_rdata,
        input  fruta_wenable, fruta_wx, fruta_wy, gen_renable, gen_rx, gen_ry,
               ready, map_full, dbg_state
    );
endinterface

// File: rtl/fruta_gen.sv
// Fruit position generator: LFSR candidates checked against the map, with a raster
// scan fallback, precomputing the next free cell so requests are served immediately.
module fruta_gen #(
    parameter int          MAPA_WIDTH  = 40,
    parameter int          MAPA_HEIGHT = 30,
    parameter int          MAX_TRIES   = 32,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input logic        clk,
    input logic        reset,
    fruta_gen_if.slave bus
);
    localparam logic [9:0]  MASK_X     = 10'((1 << $clog2(MAPA_WIDTH)) - 1);
    localparam logic [9:0]  MASK_Y     = 10'((1 << $clog2(MAPA_HEIGHT)) - 1);
    localparam logic [10:0] WIDTH_11   = 11'(MAPA_WIDTH);
    localparam logic [10:0] HEIGHT_11  = 11'(MAPA_HEIGHT);
    localparam logic [9:0]  LAST_X     = 10'(MAPA_WIDTH - 1);
    localparam logic [9:0]  LAST_Y     = 10'(MAPA_HEIGHT - 1);
    localparam logic [20:0] CELLS_LAST = 21'(MAPA_WIDTH * MAPA_HEIGHT - 1);
    localparam int          TW         = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);

    typedef enum logic [2:0] {
        S_GEN, S_READ, S_CHECK, S_READY, S_ACK, S_SCAN_READ, S_SCAN_CHECK
    } state_t;

    state_t        r_state;
    logic [15:0]   r_lfsr;
    logic [TW-1:0] r_tries;
    logic [20:0]   r_scan_cnt;
    logic          r_pending;
    logic          r_en_d;
    logic          r_ready;
    logic          r_map_full;
    logic          r_wen;
    logic          r_ren;
    logic [9:0]    r_rx;
    logic [9:0]    r_ry;
    logic [9:0]    r_wx;
    logic [9:0]    r_wy;

    logic       w_fb, w_out_x, w_out_y, w_same, w_reject;
    logic       w_req, w_empty, w_scan_self, w_tries_last, w_commit;
    logic [9:0] w_cx, w_cy, w_clip_x, w_clip_y, w_next_x, w_next_y;

    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_cx     = r_lfsr[9:0] & MASK_X;
    assign w_cy     = r_lfsr[15:6] & MASK_Y;
    assign w_out_x  = {1'b0, w_cx} >= WIDTH_11;
    assign w_out_y  = {1'b0, w_cy} >= HEIGHT_11;
    assign w_same   = (w_cx == r_wx) && (w_cy == r_wy);
    assign w_reject = w_out_x || w_out_y || w_same;
    assign w_clip_x = w_out_x ? LAST_X : w_cx;
    assign w_clip_y = w_out_y ? LAST_Y : w_cy;

    assign w_next_x = (r_rx == LAST_X) ? 10'd0 : r_rx + 10'd1;
    assign w_next_y = (r_rx != LAST_X) ? r_ry : ((r_ry == LAST_Y) ? 10'd0 : r_ry + 10'd1);

    // A request is the rising edge of fruta_enable, so a held level counts once.
    assign w_req        = bus.fruta_enable && !r_en_d;
    assign w_empty      = bus.gen_rdata == 2'b00;
    assign w_scan_self  = (r_rx == r_wx) && (r_ry == r_wy);
    assign w_tries_last = r_tries == TRIES_LAST;
    assign w_commit     = ((r_state == S_CHECK) && w_empty) ||
                          ((r_state == S_SCAN_CHECK) && w_empty && !w_scan_self);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_GEN;
            r_lfsr     <= SEED;
            r_tries    <= '0;
            r_scan_cnt <= '0;
            r_pending  <= 1'b0;
            r_en_d     <= 1'b0;
            r_ready    <= 1'b0;
            r_map_full <= 1'b0;
            r_wen      <= 1'b0;
            r_ren      <= 1'b0;
            r_rx       <= 10'd0;
            r_ry       <= 10'd0;
            r_wx       <= 10'd13;
            r_wy       <= 10'd13;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            r_en_d <= bus.fruta_enable;
            r_wen  <= 1'b0;
            r_ren  <= 1'b0;
            if (w_req && r_state != S_READY) r_pending <= 1'b1;

            case (r_state)
                S_GEN: begin
                    if (!w_reject) begin
                        r_rx    <= w_cx;
                        r_ry    <= w_cy;
                        r_ren   <= 1'b1;
                        r_state <= S_READ;
                    end else if (w_tries_last) begin
                        r_rx       <= w_clip_x;
                        r_ry       <= w_clip_y;
                        r_ren      <= 1'b1;
                        r_scan_cnt <= '0;
                        r_tries    <= '0;
                        r_state    <= S_SCAN_READ;
                    end else begin
                        r_tries <= r_tries + TW'(1);
                    end
                end
                S_READ: r_state <= S_CHECK;
                S_CHECK: begin
                    // r_rx/r_ry already hold an in-range candidate, so the scan starts there.
                    if (!w_empty && w_tries_last) begin
                        r_ren      <= 1'b1;
                        r_scan_cnt <= '0;
                        r_tries    <= '0;
                        r_state    <= S_SCAN_READ;
                    end else if (!w_empty) begin
                        r_tries <= r_tries + TW'(1);
                        r_state <= S_GEN;
                    end
                end
                S_READY: begin
                    if (w_req) begin
                        r_wen   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_ready <= 1'b0;
                    r_state <= S_GEN;
                end
                S_SCAN_READ: r_state <= S_SCAN_CHECK;
                S_SCAN_CHECK: begin
                    if (!w_commit && r_scan_cnt == CELLS_LAST) begin
                        r_map_full <= 1'b1;
                        r_tries    <= '0;
                        r_state    <= S_GEN;
                    end else if (!w_commit) begin
                        r_rx       <= w_next_x;
                        r_ry       <= w_next_y;
                        r_ren      <= 1'b1;
                        r_scan_cnt <= r_scan_cnt + 21'd1;
                        r_state    <= S_SCAN_READ;
                    end
                end
                default: r_state <= S_GEN;
            endcase

            // A request that arrived before the commit is served on READY entry.
            if (w_commit) begin
                r_wx       <= r_rx;
                r_wy       <= r_ry;
                r_ready    <= 1'b1;
                r_map_full <= 1'b0;
                r_tries    <= '0;
                if (r_pending || w_req) begin
                    r_pending <= 1'b0;
                    r_wen     <= 1'b1;
                    r_state   <= S_ACK;
                end else begin
                    r_state <= S_READY;
                end
            end
        end
    end

    assign bus.fruta_wenable = r_wen;
    assign bus.fruta_wx      = r_wx;
    assign bus.fruta_wy      = r_wy;
    assign bus.gen_renable   = r_ren;
    assign bus.gen_rx        = r_rx;
    assign bus.gen_ry        = r_ry;
    assign bus.ready         = r_ready;
    assign bus.map_full      = r_map_full;
    assign bus.dbg_state     = r_state;
endmodule

// File: tb/tb_fruta_gen.sv
// Bench for fruta_gen: a map memory model with one-cycle read latency, request
// scenarios, and checks derived from the placement rules (in range, empty, moved).
module tb_fruta_gen;
  localparam int W     = 40;
  localparam int H     = 30;
  localparam int CELLS = W * H;
  localparam int HOME  = 13 * W + 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fruta_gen_if bus();

  fruta_gen #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H), .MAX_TRIES(32), .SEED(16'hACE1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [1:0] map_mem [CELLS];
  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int consec_cnt = 0;
  int bad_addr_cnt = 0;
  logic prev_ren = 1'b0;

  // map memory: answers a read one cycle after gen_renable
  always @(posedge clk) begin
    if (reset) bus.gen_rdata <= 2'b00;
    else if (bus.gen_renable) begin
      if (int'(bus.gen_rx) < W && int'(bus.gen_ry) < H)
        bus.gen_rdata <= map_mem[int'(bus.gen_ry) * W + int'(bus.gen_rx)];
      else
        bus.gen_rdata <= 2'b11;
    end
  end

  // event counters sampled mid-cycle
  always @(negedge clk) begin
    if (bus.fruta_wenable) wen_cnt++;
    if (bus.gen_renable) ren_cnt++;
    if (bus.gen_renable && prev_ren) consec_cnt++;
    if (bus.gen_renable && (int'(bus.gen_rx) >= W || int'(bus.gen_ry) >= H)) bad_addr_cnt++;
    prev_ren = bus.gen_renable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.fruta_enable = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic fill_map(input logic [1:0] v);
    for (int i = 0; i < CELLS; i++) map_mem[i] = v;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_wen(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.fruta_wenable) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fruta_enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.ready); end
    checks++; if (bus.map_full !== 1'b0) begin errors++; $display("FAIL rst_map_full got %b want 0", bus.map_full); end
    checks++; if (bus.fruta_wenable !== 1'b0) begin errors++; $display("FAIL rst_wenable got %b want 0", bus.fruta_wenable); end
    checks++; if (bus.gen_renable !== 1'b0) begin errors++; $display("FAIL rst_renable got %b want 0", bus.gen_renable); end
    checks++; if (bus.gen_rx !== 10'd0 || bus.gen_ry !== 10'd0) begin errors++; $display("FAIL rst_raddr got (%0d,%0d) want (0,0)", bus.gen_rx, bus.gen_ry); end
    checks++; if (bus.fruta_wx !== 10'd13 || bus.fruta_wy !== 10'd13) begin errors++; $display("FAIL rst_pos got (%0d,%0d) want (13,13)", bus.fruta_wx, bus.fruta_wy); end
  endtask

  task automatic test_empty_map();
    bit ok;
    int s_wen;
    logic [9:0] px, py;
    fill_map(2'b00);
    do_reset();
    wait_ready(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_ready got 0 want 1 within 200 cycles"); end
    px = bus.fruta_wx;
    py = bus.fruta_wy;
    checks++; if (int'(px) >= W || int'(py) >= H) begin errors++; $display("FAIL empty_range got (%0d,%0d) want below (%0d,%0d)", px, py, W, H); end
    checks++; if (px == 10'd13 && py == 10'd13) begin errors++; $display("FAIL empty_moved got (%0d,%0d) want not (13,13)", px, py); end
    @(posedge clk); #1;
    s_wen = wen_cnt;
    bus.fruta_enable = 1'b1;
    @(negedge clk);
    checks++; if (bus.fruta_wenable !== 1'b0) begin errors++; $display("FAIL empty_wen_early got %b want 0", bus.fruta_wenable); end
    @(posedge clk); #1;
    bus.fruta_enable = 1'b0;
    @(negedge clk);
    checks++; if (bus.fruta_wenable !== 1'b1) begin errors++; $display("FAIL empty_wen_pulse got %b want 1", bus.fruta_wenable); end
    checks++; if (bus.fruta_wx !== px || bus.fruta_wy !== py) begin errors++; $display("FAIL empty_ack_pos got (%0d,%0d) want (%0d,%0d)", bus.fruta_wx, bus.fruta_wy, px, py); end
    @(negedge clk);
    checks++; if (bus.fruta_wenable !== 1'b0) begin errors++; $display("FAIL empty_wen_once got %b want 0", bus.fruta_wenable); end
    repeat (2) tick();
    checks++; if (wen_cnt - s_wen != 1) begin errors++; $display("FAIL empty_wen_count got %0d want 1", wen_cnt - s_wen); end
  endtask

  task automatic test_single_hole();
    bit ok;
    int s_con, s_bad;
    fill_map(2'b01);
    map_mem[21 * W + 7] = 2'b00;
    s_con = consec_cnt;
    s_bad = bad_addr_cnt;
    do_reset();
    wait_ready(8000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hole_ready got 0 want 1 within 8000 cycles"); end
    checks++; if (bus.fruta_wx !== 10'd7 || bus.fruta_wy !== 10'd21) begin errors++; $display("FAIL hole_pos got (%0d,%0d) want (7,21)", bus.fruta_wx, bus.fruta_wy); end
    tick();
    checks++; if (consec_cnt != s_con) begin errors++; $display("FAIL hole_renable_consec got %0d want 0", consec_cnt - s_con); end
    checks++; if (bad_addr_cnt != s_bad) begin errors++; $display("FAIL hole_bad_addr got %0d want 0", bad_addr_cnt - s_bad); end
  endtask

  task automatic test_map_full();
    bit ok;
    int s_ren, s_wen, reads;
    fill_map(2'b10);
    s_ren = ren_cnt;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (bus.map_full) begin ok = 1'b1; break; end
    end
    reads = ren_cnt - s_ren;
    checks++; if (!ok) begin errors++; $display("FAIL full_flag got 0 want 1 within 8000 cycles"); end
    checks++; if (reads < CELLS || reads > CELLS + 32) begin errors++; $display("FAIL full_reads got %0d want %0d..%0d", reads, CELLS, CELLS + 32); end
    checks++; if (bus.fruta_wx !== 10'd13 || bus.fruta_wy !== 10'd13) begin errors++; $display("FAIL full_pos got (%0d,%0d) want (13,13)", bus.fruta_wx, bus.fruta_wy); end
    tick();
    s_wen = wen_cnt;
    bus.fruta_enable = 1'b1;
    tick();
    bus.fruta_enable = 1'b0;
    repeat (60) tick();
    checks++; if (wen_cnt != s_wen) begin errors++; $display("FAIL full_no_wen got %0d want 0", wen_cnt - s_wen); end
    checks++; if (bus.ready !== 1'b0 || bus.map_full !== 1'b1) begin errors++; $display("FAIL full_flags got ready=%b full=%b want ready=0 full=1", bus.ready, bus.map_full); end
  endtask

  task automatic test_pending_merge();
    bit ok;
    int h0, h1, s_wen, p;
    logic last_ready;
    fill_map(2'b11);
    do h0 = $urandom_range(0, CELLS - 1); while (h0 == HOME);
    do h1 = $urandom_range(0, CELLS - 1); while (h1 == HOME || h1 == h0);
    map_mem[h0] = 2'b00;
    map_mem[h1] = 2'b00;
    s_wen = wen_cnt;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.fruta_enable = 1'b1;
      tick();
      bus.fruta_enable = 1'b0;
      tick();
    end
    last_ready = bus.ready;
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (bus.fruta_wenable) begin ok = 1'b1; break; end
      last_ready = bus.ready;
    end
    p = int'(bus.fruta_wy) * W + int'(bus.fruta_wx);
    checks++; if (!ok) begin errors++; $display("FAIL merge_wen got 0 want 1 within 8000 cycles"); end
    checks++; if (last_ready !== 1'b0 || bus.ready !== 1'b1) begin errors++; $display("FAIL merge_on_entry got prev_ready=%b ready=%b want 0/1", last_ready, bus.ready); end
    checks++; if (p != h0 && p != h1) begin errors++; $display("FAIL merge_pos got %0d want %0d or %0d", p, h0, h1); end
    @(negedge clk);
    wait_ready(8000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL merge_reready got 0 want 1 within 8000 cycles"); end
    checks++; if (int'(bus.fruta_wy) * W + int'(bus.fruta_wx) != ((p == h0) ? h1 : h0)) begin errors++; $display("FAIL merge_next_pos got (%0d,%0d) want other hole", bus.fruta_wx, bus.fruta_wy); end
    repeat (3) tick();
    checks++; if (wen_cnt - s_wen != 1) begin errors++; $display("FAIL merge_wen_count got %0d want 1", wen_cnt - s_wen); end
  endtask

  task automatic test_hold_enable();
    bit ok;
    int s_wen;
    logic [9:0] px, py;
    fill_map(2'b00);
    do_reset();
    wait_ready(200, ok);
    px = bus.fruta_wx;
    py = bus.fruta_wy;
    tick();
    s_wen = wen_cnt;
    bus.fruta_enable = 1'b1;
    repeat (5) tick();
    bus.fruta_enable = 1'b0;
    wait_ready(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_reready got 0 want 1 within 200 cycles"); end
    checks++; if (bus.fruta_wx == px && bus.fruta_wy == py) begin errors++; $display("FAIL hold_new_pos got (%0d,%0d) want a different cell", px, py); end
    checks++; if (int'(bus.fruta_wx) >= W || int'(bus.fruta_wy) >= H) begin errors++; $display("FAIL hold_range got (%0d,%0d) want in map", bus.fruta_wx, bus.fruta_wy); end
    repeat (10) tick();
    checks++; if (wen_cnt - s_wen != 1) begin errors++; $display("FAIL hold_wen_count got %0d want 1", wen_cnt - s_wen); end
  endtask

  task automatic test_reset_in_ack();
    bit ok;
    int s_wen;
    fill_map(2'b00);
    do_reset();
    wait_ready(200, ok);
    tick();
    bus.fruta_enable = 1'b1;
    tick();
    bus.fruta_enable = 1'b0;
    @(negedge clk);
    checks++; if (bus.fruta_wenable !== 1'b1) begin errors++; $display("FAIL ackrst_in_ack got %b want 1", bus.fruta_wenable); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.fruta_wenable !== 1'b0) begin errors++; $display("FAIL ackrst_wen got %b want 0", bus.fruta_wenable); end
    checks++; if (bus.fruta_wx !== 10'd13 || bus.fruta_wy !== 10'd13 || bus.ready !== 1'b0) begin errors++; $display("FAIL ackrst_state got (%0d,%0d) ready=%b want (13,13) ready=0", bus.fruta_wx, bus.fruta_wy, bus.ready); end
    tick();
    s_wen = wen_cnt;
    reset = 1'b0;
    repeat (40) tick();
    checks++; if (wen_cnt != s_wen) begin errors++; $display("FAIL ackrst_no_wen got %0d want 0", wen_cnt - s_wen); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL ackrst_reready got %b want 1", bus.ready); end
  endtask

  task automatic test_random();
    bit ok;
    int dens, base, s_wen, reqs;
    logic [9:0] prev_x, prev_y;
    for (int r = 0; r < 3; r++) begin
      dens = $urandom_range(0, 80);
      for (int i = 0; i < CELLS; i++)
        map_mem[i] = ($urandom_range(0, 99) < dens) ? 2'($urandom_range(1, 3)) : 2'b00;
      base = $urandom_range(0, CELLS - 1);
      map_mem[base] = 2'b00;
      map_mem[(base + 7) % CELLS] = 2'b00;
      map_mem[(base + 500) % CELLS] = 2'b00;
      s_wen = wen_cnt;
      reqs = 0;
      do_reset();
      prev_x = 10'd13;
      prev_y = 10'd13;
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          tick();
          bus.fruta_enable = 1'b1;
          tick();
          bus.fruta_enable = 1'b0;
          wait_wen(8000, ok);
        end else begin
          wait_ready(8000, ok);
          repeat ($urandom_range(0, 5)) @(negedge clk);
          tick();
          bus.fruta_enable = 1'b1;
          tick();
          bus.fruta_enable = 1'b0;
          @(negedge clk);
        end
        reqs++;
        checks++; if (!ok || bus.fruta_wenable !== 1'b1) begin errors++; $display("FAIL rnd_wen r%0d k%0d got %b want 1", r, k, bus.fruta_wenable); end
        checks++; if (int'(bus.fruta_wx) >= W || int'(bus.fruta_wy) >= H) begin errors++; $display("FAIL rnd_range got (%0d,%0d) want in map", bus.fruta_wx, bus.fruta_wy); end
        else begin
          checks++; if (map_mem[int'(bus.fruta_wy) * W + int'(bus.fruta_wx)] !== 2'b00) begin errors++; $display("FAIL rnd_empty got cell (%0d,%0d) value %0d want 0", bus.fruta_wx, bus.fruta_wy, map_mem[int'(bus.fruta_wy) * W + int'(bus.fruta_wx)]); end
        end
        checks++; if (bus.fruta_wx == prev_x && bus.fruta_wy == prev_y) begin errors++; $display("FAIL rnd_moved got (%0d,%0d) want a different cell", prev_x, prev_y); end
        prev_x = bus.fruta_wx;
        prev_y = bus.fruta_wy;
        @(negedge clk);
      end
      repeat (3) tick();
      checks++; if (wen_cnt - s_wen != reqs) begin errors++; $display("FAIL rnd_wen_count got %0d want %0d", wen_cnt - s_wen, reqs); end
    end
  endtask

  initial begin
    bus.fruta_enable = 1'b0;
    test_reset();
    test_empty_map();
    test_single_hole();
    test_map_full();
    test_pending_merge();
    test_hold_enable();
    test_reset_in_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fruta_gen.md
FRUTA_GEN -- requirements
Module: fruta_gen

Interface
REQ-001 Parameter MAPA_WIDTH, default 40: map columns, range 2..1024.
REQ-002 Parameter MAPA_HEIGHT, default 30: map rows, range 2..1024.
REQ-003 Parameter MAX_TRIES, default 32: random candidates tried before falling back to a linear scan.
REQ-004 Parameter SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-005 Port clk, input, 1: single clock; all logic is on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port fruta_enable, input, 1: request for a new fruit position, sampled each cycle.
REQ-008 Port fruta_wenable, output, 1: one-cycle pulse marking a request as served.
REQ-009 Port fruta_wx, output, 10: fruit column.
REQ-010 Port fruta_wy, output, 10: fruit row.
REQ-011 Port gen_renable, output, 1: map read strobe.
REQ-012 Ports gen_rx and gen_ry, output, 10 each: map read address.
REQ-013 Port gen_rdata, input, 2: map cell value; valid exactly 1 cycle after gen_renable; 2'b00 means empty.
REQ-014 Port ready, output, 1: high when fruta_wx/fruta_wy hold a validated position not yet handed out.
REQ-015 Port map_full, output, 1: high when the last full scan found no empty cell.

Function
REQ-016 fruta_wx/fruta_wy SHALL change only on the cycle a new validated candidate is committed, and SHALL be stable for at least the cycle after fruta_enable is seen, so the requester can sample them one cycle after asserting fruta_enable.
REQ-017 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle while not in reset.
REQ-018 Candidate cx SHALL be LFSR[9:0] masked to ceil(log2(MAPA_WIDTH)) bits.
REQ-019 Candidate cy SHALL be LFSR[15:6] masked to ceil(log2(MAPA_HEIGHT)) bits.
REQ-020 A candidate SHALL be rejected without a map read if cx >= MAPA_WIDTH, cy >= MAPA_HEIGHT, or (cx,cy) equals the current fruta_wx/fruta_wy.
REQ-021 State machine states: GEN, READ, CHECK, READY, ACK, SCAN_READ, SCAN_CHECK.
REQ-022 GEN: form a candidate; if rejected, increment tries and stay in GEN; otherwise assert gen_renable with gen_rx=cx, gen_ry=cy and go to READ.
REQ-023 READ: one wait cycle with gen_renable low; go to CHECK.
REQ-024 CHECK: if gen_rdata==2'b00, commit the candidate to fruta_wx/fruta_wy, set ready=1 and go to READY; otherwise increment tries and return to GEN.
REQ-025 When tries reaches MAX_TRIES, go to SCAN_READ with the scan pointer at the last candidate clipped into range.
REQ-026 SCAN_READ/SCAN_CHECK: read each cell in raster order (x+1, wrapping x to 0 and y+1, wrapping y to 0); commit the first empty cell other than the current position.
REQ-027 If a scan visits MAPA_WIDTH*MAPA_HEIGHT cells with no hit, set map_full=1, keep outputs unchanged, reset tries to 0 and go to GEN; a later successful commit clears map_full.
REQ-028 tries SHALL reset to 0 on every commit.
REQ-029 READY: on fruta_enable=1, go to ACK.
REQ-030 ACK: assert fruta_wenable for exactly this cycle, keep outputs unchanged, clear ready, then go to GEN to precompute the next position.
REQ-031 A fruta_enable seen in any state other than READY SHALL be latched as pending; on entry to READY, a pending request SHALL go straight to ACK and clear the pending flag.
REQ-032 Further fruta_enable pulses while a request is pending SHALL be merged into that one request.
REQ-033 Each request SHALL produce exactly one fruta_wenable pulse; a request held high for N cycles in READY SHALL count as one request.
REQ-034 gen_renable SHALL be high only in the cycle a read is issued, never in two consecutive cycles.

Reset
REQ-035 On reset=1 at a rising edge: state=GEN, LFSR=SEED, tries=0, pending=0, ready=0, map_full=0, fruta_wenable=0, gen_renable=0, gen_rx=0, gen_ry=0, fruta_wx=13, fruta_wy=13.
REQ-036 Reset asserted mid-search or during ACK SHALL abort the operation; no fruta_wenable pulse may follow the reset.

Verification
REQ-037 Empty map model, reset released, wait until ready=1; then pulse fruta_enable -> fruta_wenable exactly 1 cycle later; fruta_wx<40, fruta_wy<30, position differs from (13,13).
REQ-038 Map model with every cell nonzero except (7,21) -> committed position is (7,21); gen_renable never high on two consecutive cycles.
REQ-039 Map model with every cell nonzero -> map_full=1 after 1200 scan reads; fruta_wx/fruta_wy unchanged; fruta_enable gives no fruta_wenable pulse.
REQ-040 Pulse fruta_enable during GEN, and twice more before READY -> exactly one fruta_wenable pulse, issued on READY entry.
REQ-041 Hold fruta_enable high for 5 cycles in READY -> one fruta_wenable pulse; the next position is precomputed and ready rises again.
REQ-042 Assert reset on the ACK cycle -> fruta_wenable=0 on the following cycle; outputs return to (13,13) with ready=0.
